spi_flash_seq: RTL and testbench

Command sequencer for the SPI flash/ROM command engine. It turns a single host request (page write or block read) into the ordered engine commands the flash requires:
- write: write-enable, status check, data write, busy poll;
- read: busy poll, data read.

It sits between the system-side requester and the command engine driven by the 3-bit `controll`/`enable` pair. It owns status polling, poll pacing and timeout.

---
 rtl/spi_flash_pkg.sv | 32 +++
 rtl/spi_poll_timer.sv | 46 ++++
 rtl/spi_flash_seq.sv | 166 ++++++++++++++++
 tb/tb_spi_flash_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash command sequencer and the command engine.
// Command codes, status bit positions, error codes and FSM/phase encodings.
package spi_flash_pkg;

  localparam logic [2:0] CMD_IDLE      = 3'b000;
  localparam logic [2:0] CMD_WRITE     = 3'b001;
  localparam logic [2:0] CMD_RD_STATUS = 3'b010;
  localparam logic [2:0] CMD_WR_DATA   = 3'b011;
  localparam logic [2:0] CMD_RD_DATA   = 3'b100;

  localparam int unsigned STAT_WIP = 0;
  localparam int unsigned STAT_WEL = 1;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_WEL     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERR} state_e;
  typedef enum logic [2:0] {PH_WREN, PH_CHKWEL, PH_WDATA, PH_POLL, PH_RDATA} phase_e;

  function automatic logic [2:0] phase_cmd(input phase_e ph);
    case (ph)
      PH_WREN:   return CMD_WRITE;
      PH_CHKWEL: return CMD_RD_STATUS;
      PH_WDATA:  return CMD_WR_DATA;
      PH_POLL:   return CMD_RD_STATUS;
      PH_RDATA:  return CMD_RD_DATA;
      default:   return CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/spi_poll_timer.sv
// Inter-command gap down-counter and saturating busy-poll counter.
module spi_poll_timer #(
  parameter int unsigned POLL_MAX = 255,
  parameter int unsigned POLL_GAP = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic long_gap,
  input  logic poll_clr,
  input  logic poll_inc,
  output logic tick_done,
  output logic limit_hit
);

  localparam int unsigned GapW = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);
  localparam logic [7:0] PollLim = (POLL_MAX > 255) ? 8'hff : 8'(POLL_MAX);

  logic [GapW-1:0] gap_cnt;
  logic [7:0]      poll_cnt;
  logic [7:0]      poll_sat;

  // A short gap loads zero so the sequencer spends exactly one cycle in S_GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (start) begin
      gap_cnt <= long_gap ? GapW'(POLL_GAP) : '0;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GapW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || poll_clr) begin
      poll_cnt <= 8'h00;
    end else if (poll_inc) begin
      poll_cnt <= poll_sat;
    end
  end

  assign poll_sat  = (poll_cnt == 8'hff) ? 8'hff : poll_cnt + 8'd1;
  assign limit_hit = (poll_sat >= PollLim);
  assign tick_done = (gap_cnt == '0);

endmodule

// File: rtl/spi_flash_seq.sv
// Turns one host page-write / block-read request into the ordered engine
// commands, handling status polling, poll pacing and timeout.
module spi_flash_seq
  import spi_flash_pkg::*;
#(
  parameter int unsigned POLL_MAX = 255,
  parameter int unsigned POLL_GAP = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       op_wr,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [2:0] controll,
  output logic       enable,
  input  logic       eng_done,
  input  logic [7:0] eng_status
);

  state_e     state;
  phase_e     phase;
  phase_e     phase_next;
  logic       op_wr_q;
  logic       accept;
  logic       t_start, t_long, p_clr, p_inc;
  logic       tick_done, limit_hit;
  logic       go_done, go_err;
  logic [1:0] err_next;
  logic       unused_status;

  assign unused_status = ^eng_status[7:2];

  // A completion coinciding with the issue pulse belongs to no command of ours.
  assign accept = (state == S_WAIT) && eng_done && !enable;

  always_comb begin
    t_start    = 1'b0;
    t_long     = 1'b0;
    p_clr      = 1'b0;
    p_inc      = 1'b0;
    go_done    = 1'b0;
    go_err     = 1'b0;
    err_next   = ERR_NONE;
    phase_next = phase;
    if (state == S_IDLE && req) p_clr = 1'b1;
    if (accept) begin
      case (phase)
        PH_WREN: begin
          phase_next = PH_CHKWEL;
          t_start    = 1'b1;
        end
        PH_CHKWEL: begin
          if (eng_status[STAT_WEL]) begin
            phase_next = PH_WDATA;
            t_start    = 1'b1;
          end else begin
            go_err   = 1'b1;
            err_next = ERR_WEL;
          end
        end
        PH_WDATA: begin
          phase_next = PH_POLL;
          t_start    = 1'b1;
          p_clr      = 1'b1;
        end
        PH_POLL: begin
          if (eng_status[STAT_WIP]) begin
            p_inc = 1'b1;
            if (limit_hit) begin
              go_err   = 1'b1;
              err_next = ERR_TIMEOUT;
            end else begin
              t_start = 1'b1;
              t_long  = 1'b1;
            end
          end else if (op_wr_q) begin
            go_done = 1'b1;
          end else begin
            phase_next = PH_RDATA;
            t_start    = 1'b1;
          end
        end
        default: go_done = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      phase    <= PH_WREN;
      op_wr_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
      controll <= CMD_IDLE;
      enable   <= 1'b0;
    end else begin
      enable <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          busy     <= 1'b0;
          controll <= CMD_IDLE;
          if (req) begin
            op_wr_q  <= op_wr;
            err_code <= ERR_NONE;
            phase    <= op_wr ? PH_WREN : PH_POLL;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          busy     <= 1'b1;
          controll <= phase_cmd(phase);
          enable   <= 1'b1;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (accept) begin
            phase <= phase_next;
            if (go_err) begin
              err_code <= err_next;
              state    <= S_ERR;
            end else if (go_done) begin
              state <= S_DONE;
            end else begin
              state <= S_GAP;
            end
          end
        end
        S_GAP: if (tick_done) state <= S_ISSUE;
        S_DONE: begin
          done     <= 1'b1;
          controll <= CMD_IDLE;
          state    <= S_IDLE;
        end
        S_ERR: begin
          error    <= 1'b1;
          controll <= CMD_IDLE;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  spi_poll_timer #(
    .POLL_MAX(POLL_MAX),
    .POLL_GAP(POLL_GAP)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (t_start),
    .long_gap (t_long),
    .poll_clr (p_clr),
    .poll_inc (p_inc),
    .tick_done(tick_done),
    .limit_hit(limit_hit)
  );

endmodule

// File: tb/tb_spi_flash_seq.sv
// Bench for spi_flash_seq: directed flows plus random transactions checked
// against a command-list model of the request flows.
module tb_spi_flash_seq;
  import spi_flash_pkg::*;

  localparam int unsigned TB_MAX = 4;
  localparam int unsigned TB_GAP = 3;

  logic       clk = 1'b0;
  logic       rst, req, op_wr, eng_done;
  logic [7:0] eng_status;
  logic       busy, done, error, enable;
  logic [1:0] err_code;
  logic [2:0] controll;

  int ncmp = 0, nfail = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, en_cnt = 0, both_cnt = 0;

  logic [2:0] m_cmd[$];
  logic [7:0] m_stat[$];
  bit         m_busy[$];
  int         m_out;  // 0 done, 1 WEL error, 2 timeout

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (error === 1'b1) err_cnt++;
    if (enable === 1'b1) en_cnt++;
    if (done === 1'b1 && error === 1'b1) both_cnt++;
  end

  spi_flash_seq #(
    .POLL_MAX(TB_MAX),
    .POLL_GAP(TB_GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_wr     (op_wr),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .controll  (controll),
    .enable    (enable),
    .eng_done  (eng_done),
    .eng_status(eng_status)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_enable(input int bound, output int edge_no, output bit ok);
    ok = 1'b0;
    edge_no = -1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (enable === 1'b1) begin
        ok = 1'b1;
        edge_no = cyc;
        break;
      end
    end
  endtask

  task automatic push(input logic [2:0] c, input logic [7:0] s, input bit b);
    m_cmd.push_back(c);
    m_stat.push_back(s);
    m_busy.push_back(b);
  endtask

  // Expected command list and outcome for one request.
  task automatic build_model(input bit wr, input bit wel_ok, input int n_busy);
    logic [7:0] r;
    m_cmd.delete();
    m_stat.delete();
    m_busy.delete();
    if (wr) begin
      push(CMD_WRITE, 8'($urandom), 1'b0);
      r = 8'($urandom);
      r[1] = wel_ok;
      push(CMD_RD_STATUS, r, 1'b0);
      if (!wel_ok) begin
        m_out = 1;
        return;
      end
      push(CMD_WR_DATA, 8'($urandom), 1'b0);
    end
    for (int k = 0; k < int'(TB_MAX); k++) begin
      r = 8'($urandom);
      r[0] = (k < n_busy);
      push(CMD_RD_STATUS, r, r[0]);
      if (!r[0]) break;
    end
    if (n_busy >= int'(TB_MAX)) begin
      m_out = 2;
      return;
    end
    if (!wr) push(CMD_RD_DATA, 8'($urandom), 1'b0);
    m_out = 0;
  endtask

  task automatic run_txn(input bit wr, input bit wel_ok, input int n_busy, input bit poke,
                         input bit early);
    int en_edge, m_edge, exp_edge, lat, d0, e0, n0;
    bit ok;
    build_model(wr, wel_ok, n_busy);
    d0 = done_cnt;
    e0 = err_cnt;
    n0 = en_cnt;
    req = 1'b1;
    op_wr = wr;
    tick();
    exp_edge = cyc + 1;
    req = 1'b0;
    op_wr = 1'($urandom);
    for (int i = 0; i < m_cmd.size(); i++) begin
      wait_enable(40, en_edge, ok);
      chk("enable_seen", ok, 1);
      if (!ok) break;
      chk("enable_time", en_edge, exp_edge);
      chk("cmd", controll, m_cmd[i]);
      chk("busy_on", busy, 1);
      lat = $urandom_range(1, 4);
      for (int j = 0; j < lat; j++) begin
        if (early && i == 0 && j == 0) eng_done = 1'b1;
        if (poke && j == 0) req = 1'b1;
        tick();
        eng_done = 1'b0;
        req = 1'b0;
      end
      eng_done = 1'b1;
      eng_status = m_stat[i];
      tick();
      eng_done = 1'b0;
      eng_status = 8'($urandom);
      m_edge = cyc;
      chk("cmd_hold", controll, m_cmd[i]);
      exp_edge = m_edge + 2 + (m_busy[i] ? int'(TB_GAP) : 0);
    end
    tick();
    chk("done_pulse", done, m_out == 0);
    chk("error_pulse", error, m_out != 0);
    chk("err_code", err_code, (m_out == 1) ? 1 : (m_out == 2) ? 2 : 0);
    tick();
    chk("busy_off", busy, 0);
    chk("done_single", done, 0);
    tick();
    chk("enable_count", en_cnt - n0, m_cmd.size());
    chk("done_count", done_cnt - d0, m_out == 0);
    chk("error_count", err_cnt - e0, m_out != 0);
    chk("err_code_held", err_code, (m_out == 1) ? 1 : (m_out == 2) ? 2 : 0);
  endtask

  initial begin
    int en_edge, n0, d0, e0;
    bit ok;
    rst = 1'b1;
    req = 1'b0;
    op_wr = 1'b0;
    eng_done = 1'b0;
    eng_status = 8'h00;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_controll", controll, 0);
    chk("rst_enable", enable, 0);
    rst = 1'b0;
    tick();

    // Stray completion while idle.
    eng_done = 1'b1;
    eng_status = 8'hff;
    tick();
    eng_done = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("stray_enable", en_cnt, 0);
    chk("stray_done", done_cnt + err_cnt, 0);
    chk("stray_busy", busy, 0);

    run_txn(1'b0, 1'b1, 0, 1'b0, 1'b0);  // read, flash idle
    run_txn(1'b1, 1'b1, 2, 1'b0, 1'b0);  // write, two busy polls
    run_txn(1'b1, 1'b0, 0, 1'b0, 1'b0);  // WEL missing
    run_txn(1'b1, 1'b1, 4, 1'b0, 1'b0);  // write timeout
    run_txn(1'b0, 1'b1, 6, 1'b0, 1'b0);  // read timeout
    run_txn(1'b0, 1'b1, 1, 1'b1, 1'b1);  // req while busy, early eng_done

    // Reset while waiting on WR_DATA; its late completion must be ignored.
    n0 = en_cnt;
    d0 = done_cnt;
    e0 = err_cnt;
    req = 1'b1;
    op_wr = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_enable(40, en_edge, ok);
      chk("rmid_enable", ok, 1);
      tick();
      eng_done = 1'b1;
      eng_status = 8'h02;
      tick();
      eng_done = 1'b0;
    end
    wait_enable(40, en_edge, ok);
    chk("rmid_wdata", controll, CMD_WR_DATA);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid_busy", busy, 0);
    chk("rmid_controll", controll, 0);
    chk("rmid_enable0", enable, 0);
    chk("rmid_pulses", {done, error, err_code}, 0);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rmid_no_cmd", en_cnt - n0, 3);
    chk("rmid_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    run_txn(1'b1, 1'b1, 1, 1'b0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      run_txn(1'($urandom), ($urandom % 4) != 0, $urandom_range(0, TB_MAX + 1),
              1'($urandom), 1'($urandom));
    end

    chk("done_error_exclusive", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
